// File: rtl/legv8_pkg.sv
// legv8_pkg: shared opcodes, ALU_OP encodings, FSM states and instruction classes
package legv8_pkg;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'd1986;
    localparam logic [10:0] OP_STUR = 11'd1984;
    localparam logic [7:0]  OP_CBZ  = 8'd180;
    localparam logic [5:0]  OP_B    = 6'd5;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_PASSB = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_ERROR  = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        CLS_R, CLS_LD, CLS_ST, CLS_CBZ, CLS_B, CLS_ILL
    } instr_class_t;

endpackage

// File: rtl/legv8_instr_classify.sv
// legv8_instr_classify: combinational instruction-class decode of the latched IR
// ports: ir (latched instruction word) -> cls (instruction class, first match wins)
module legv8_instr_classify
    import legv8_pkg::*;
(
    input  logic [31:0]  ir,
    output instr_class_t cls
);

    logic [10:0] op;

    assign op = ir[31:21];

    // CBZ and B are checked first because their short opcode fields overlap the 11-bit space
    always_comb
        cls = (ir[31:24] == OP_CBZ) ? CLS_CBZ :
              (ir[31:26] == OP_B)   ? CLS_B   :
              (op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_ORR) ? CLS_R :
              (op == OP_LDUR) ? CLS_LD :
              (op == OP_STUR) ? CLS_ST : CLS_ILL;

endmodule

// File: rtl/legv8_multicycle_ctrl.sv
// legv8_multicycle_ctrl: multi-cycle LEGv8 control FSM with memory handshakes and ack timeout
// ports: clk/rst (async high); imem_rdata/imem_ack -> imem_req; dmem_ack -> dmem_req; alu_zero (CBZ test);
//        ir_write, pc_write, pc_src and datapath controls reg2loc..uncond_branch, alu_op;
//        state_o (debug); sticky illegal and timeout flags
module legv8_multicycle_ctrl
    import legv8_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CW      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic        imem_req,
    input  logic        dmem_ack,
    output logic        dmem_req,
    input  logic        alu_zero,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic        reg2loc,
    output logic        alu_src,
    output logic        mem2reg,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        branch,
    output logic        uncond_branch,
    output logic [1:0]  alu_op,
    output logic [2:0]  state_o,
    output logic        illegal,
    output logic        timeout
);

    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

    state_t       state, next;
    instr_class_t cls;
    logic [31:0]  ir;
    logic [CW-1:0] cnt;
    logic req, ack, expire, is_ld, is_st, is_cbz, is_b, reg_b;

    legv8_instr_classify u_classify (
        .ir  (ir),
        .cls (cls)
    );

    assign is_ld   = cls == CLS_LD;
    assign is_st   = cls == CLS_ST;
    assign is_cbz  = cls == CLS_CBZ;
    assign is_b    = cls == CLS_B;
    assign reg_b   = is_cbz | is_st;
    assign req     = state == S_FETCH || state == S_MEM;
    assign ack     = state == S_FETCH ? imem_ack : dmem_ack;
    // the final allowed wait cycle expires only if the ack is still low in it
    assign expire  = TIMEOUT != 0 && req && !ack && cnt == LIMIT;
    assign state_o = state;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state   <= S_FETCH;
            ir      <= '0;
            cnt     <= '0;
            illegal <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= next;
            ir      <= (state == S_FETCH && imem_ack) ? imem_rdata : ir;
            cnt     <= (next != state) ? '0 : (req && !ack && cnt != '1) ? cnt + 1'b1 : cnt;
            illegal <= illegal | (state == S_DECODE && cls == CLS_ILL);
            timeout <= timeout | expire;
        end

    always_comb begin
        next          = state;
        imem_req      = 1'b0;
        dmem_req      = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_src        = 1'b0;
        reg2loc       = 1'b0;
        alu_src       = 1'b0;
        mem2reg       = 1'b0;
        reg_write     = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        branch        = 1'b0;
        uncond_branch = 1'b0;
        alu_op        = ALU_ADD;
        case (state)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_write = imem_ack;
                next     = imem_ack ? S_DECODE : expire ? S_ERROR : S_FETCH;
            end
            S_DECODE: begin
                reg2loc = reg_b;
                next    = cls == CLS_ILL ? S_ERROR : S_EXEC;
            end
            S_EXEC: begin
                reg2loc       = reg_b;
                alu_src       = is_ld | is_st;
                alu_op        = cls == CLS_R ? ALU_FUNCT : is_cbz ? ALU_PASSB : ALU_ADD;
                branch        = is_cbz;
                uncond_branch = is_b;
                pc_write      = is_cbz | is_b;
                pc_src        = is_cbz ? alu_zero : is_b;
                next          = cls == CLS_R ? S_WB : (is_ld | is_st) ? S_MEM : S_FETCH;
            end
            S_MEM: begin
                dmem_req  = 1'b1;
                reg2loc   = is_st;
                alu_src   = 1'b1;
                mem_read  = is_ld;
                mem_write = is_st;
                pc_write  = is_st & dmem_ack;
                next      = dmem_ack ? (is_ld ? S_WB : S_FETCH) : expire ? S_ERROR : S_MEM;
            end
            S_WB: begin
                reg_write = 1'b1;
                mem2reg   = is_ld;
                pc_write  = 1'b1;
                next      = S_FETCH;
            end
            default: next = S_ERROR;
        endcase
    end

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// tb_legv8_multicycle_ctrl: directed cycle-by-cycle check of the multi-cycle control FSM
module tb_legv8_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_rdata = '0;
    logic        imem_ack = 1'b0, dmem_ack = 1'b0, alu_zero = 1'b0;
    logic        imem_req, dmem_req, ir_write, pc_write, pc_src, reg2loc, alu_src, mem2reg;
    logic        reg_write, mem_read, mem_write, branch, uncond_branch, illegal, timeout;
    logic [1:0]  alu_op;
    logic [2:0]  state_o;
    logic [14:0] ctrl;
    int          total = 0, bad = 0;

    localparam logic [31:0] I_ADD  = 32'h8B020020;
    localparam logic [31:0] I_LDUR = 32'hF8400000;
    localparam logic [31:0] I_STUR = 32'hF8000000;
    localparam logic [31:0] I_CBZ  = 32'hB4000000;
    localparam logic [31:0] I_B    = 32'h14000000;
    localparam logic [31:0] I_BAD  = 32'hFFFFFFFF;

    // ctrl = {imem_req,dmem_req,ir_write}_{pc_write,pc_src}_{reg2loc,alu_src,mem2reg,reg_write}_{mem_read,mem_write,branch,uncond}_alu_op
    localparam logic [14:0] C_IDLE = 15'b000_00_0000_0000_00;
    localparam logic [14:0] C_FREQ = 15'b100_00_0000_0000_00;
    localparam logic [14:0] C_FACK = 15'b101_00_0000_0000_00;

    assign ctrl = {imem_req, dmem_req, ir_write, pc_write, pc_src, reg2loc, alu_src, mem2reg,
                   reg_write, mem_read, mem_write, branch, uncond_branch, alu_op};

    legv8_multicycle_ctrl #(.TIMEOUT(4), .CW(8)) dut (
        .clk(clk), .rst(rst), .imem_rdata(imem_rdata), .imem_ack(imem_ack), .imem_req(imem_req),
        .dmem_ack(dmem_ack), .dmem_req(dmem_req), .alu_zero(alu_zero), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .reg2loc(reg2loc), .alu_src(alu_src),
        .mem2reg(mem2reg), .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .branch(branch), .uncond_branch(uncond_branch), .alu_op(alu_op), .state_o(state_o),
        .illegal(illegal), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // drive one cycle's inputs after the falling edge, then check state and controls
    task automatic step(input string tag, input logic ia, input logic da, input logic z,
                        input logic [31:0] rd, input logic [2:0] es, input logic [14:0] ec);
        @(negedge clk);
        rst = 1'b0;
        imem_ack = ia;
        dmem_ack = da;
        alu_zero = z;
        imem_rdata = rd;
        #1;
        chk(tag, {14'd0, state_o, ctrl}, {14'd0, es, ec});
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        #1;
        chk(tag, {27'd0, state_o, illegal, timeout}, {27'd0, 3'd0, 1'b0, 1'b0});
    endtask

    initial begin
        #3;
        chk("rst_hold", {14'd0, state_o, ctrl}, {14'd0, 3'd0, C_FREQ});
        chk("rst_flags", {30'd0, illegal, timeout}, 32'd0);
        step("post_rst", 0, 0, 0, '0, 3'd0, C_FREQ);
        // ADD, zero-wait
        step("add_f", 1, 0, 0, I_ADD, 3'd0, C_FACK);
        step("add_d_stray_acks", 1, 1, 0, I_LDUR, 3'd1, C_IDLE);
        step("add_e", 0, 0, 0, '0, 3'd2, 15'b000_00_0000_0000_10);
        step("add_wb", 0, 0, 0, '0, 3'd4, 15'b000_10_0001_0000_00);
        // LDUR with dmem_ack on the 4th MEM cycle (limit cycle, ack wins)
        step("ld_f", 1, 0, 0, I_LDUR, 3'd0, C_FACK);
        step("ld_d", 0, 0, 0, '0, 3'd1, C_IDLE);
        step("ld_e", 0, 0, 0, '0, 3'd2, 15'b000_00_0100_0000_00);
        step("ld_m1", 0, 0, 0, '0, 3'd3, 15'b010_00_0100_1000_00);
        step("ld_m2", 0, 0, 0, '0, 3'd3, 15'b010_00_0100_1000_00);
        step("ld_m3", 0, 0, 0, '0, 3'd3, 15'b010_00_0100_1000_00);
        step("ld_m4", 0, 1, 0, '0, 3'd3, 15'b010_00_0100_1000_00);
        step("ld_wb", 0, 0, 0, '0, 3'd4, 15'b000_10_0011_0000_00);
        chk("ld_no_timeout", {31'd0, timeout}, 32'd0);
        // CBZ taken and not taken
        step("cbz1_f", 1, 0, 0, I_CBZ, 3'd0, C_FACK);
        step("cbz1_d", 0, 0, 0, '0, 3'd1, 15'b000_00_1000_0000_00);
        step("cbz1_e", 0, 0, 1, '0, 3'd2, 15'b000_11_1000_0010_01);
        step("cbz0_f", 1, 0, 0, I_CBZ, 3'd0, C_FACK);
        step("cbz0_d", 0, 0, 1, '0, 3'd1, 15'b000_00_1000_0000_00);
        step("cbz0_e", 0, 0, 0, '0, 3'd2, 15'b000_10_1000_0010_01);
        // B
        step("b_f", 1, 0, 0, I_B, 3'd0, C_FACK);
        step("b_d", 0, 0, 0, '0, 3'd1, C_IDLE);
        step("b_e", 0, 0, 0, '0, 3'd2, 15'b000_11_0000_0001_00);
        // STUR with one wait cycle
        step("st_f", 1, 0, 0, I_STUR, 3'd0, C_FACK);
        step("st_d", 0, 0, 0, '0, 3'd1, 15'b000_00_1000_0000_00);
        step("st_e", 0, 0, 0, '0, 3'd2, 15'b000_00_1100_0000_00);
        step("st_m1", 0, 0, 0, '0, 3'd3, 15'b010_00_1100_0100_00);
        step("st_m2", 0, 1, 0, '0, 3'd3, 15'b010_10_1100_0100_00);
        // illegal opcode
        step("ill_f", 1, 0, 0, I_BAD, 3'd0, C_FACK);
        step("ill_d", 0, 0, 0, '0, 3'd1, C_IDLE);
        step("ill_err", 1, 1, 0, I_ADD, 3'd7, C_IDLE);
        step("ill_err2", 1, 1, 0, I_ADD, 3'd7, C_IDLE);
        chk("ill_sticky", {30'd0, illegal, timeout}, 32'd2);
        do_reset("ill_rst");
        // fetch timeout: four unanswered request cycles
        step("to_c1", 0, 0, 0, '0, 3'd0, C_FREQ);
        step("to_c2", 0, 0, 0, '0, 3'd0, C_FREQ);
        step("to_c3", 0, 0, 0, '0, 3'd0, C_FREQ);
        step("to_c4", 0, 0, 0, '0, 3'd0, C_FREQ);
        step("to_err", 1, 0, 0, I_ADD, 3'd7, C_IDLE);
        chk("to_flags", {30'd0, illegal, timeout}, 32'd1);
        do_reset("to_rst");
        // ack arrives on the 4th request cycle
        step("ack4_c1", 0, 0, 0, '0, 3'd0, C_FREQ);
        step("ack4_c2", 0, 0, 0, '0, 3'd0, C_FREQ);
        step("ack4_c3", 0, 0, 0, '0, 3'd0, C_FREQ);
        step("ack4_c4", 1, 0, 0, I_ADD, 3'd0, C_FACK);
        step("ack4_d", 0, 0, 0, '0, 3'd1, C_IDLE);
        chk("ack4_flags", {30'd0, illegal, timeout}, 32'd0);
        step("ack4_e", 0, 0, 0, '0, 3'd2, 15'b000_00_0000_0000_10);
        step("ack4_wb", 0, 0, 0, '0, 3'd4, 15'b000_10_0001_0000_00);
        // async reset in the middle of a LDUR memory wait
        step("ar_f", 1, 0, 0, I_LDUR, 3'd0, C_FACK);
        step("ar_d", 0, 0, 0, '0, 3'd1, C_IDLE);
        step("ar_e", 0, 0, 0, '0, 3'd2, 15'b000_00_0100_0000_00);
        step("ar_m1", 0, 0, 0, '0, 3'd3, 15'b010_00_0100_1000_00);
        @(negedge clk);
        dmem_ack = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("ar_async", {14'd0, state_o, ctrl}, {14'd0, 3'd0, C_FREQ});
        step("ar_release", 0, 0, 0, '0, 3'd0, C_FREQ);
        chk("ar_flags", {30'd0, illegal, timeout}, 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=stuck exp=finish");
        $fatal(1);
    end

endmodule

// File: doc/legv8_multicycle_ctrl.md
Name: legv8_multicycle_ctrl

Overview:
Multi-cycle sequencer for the LEGv8 datapath (ADD/SUB/AND/ORR, LDUR, STUR, CBZ, B). It replaces per-instruction combinational control with an FSM that fetches, decodes, executes, accesses memory and writes back over several cycles. It handshakes with instruction and data memories and drives the existing datapath control signals (REG2LOC, ALU_SRC, MEM2REG, REG_WRITE, MEM_READ, MEM_WRITE, BRANCH, UNCOND_BRANCH, ALU_OP) plus PC and IR enables.

Parameters:
TIMEOUT, 255, maximum cycles to wait for imem_ack/dmem_ack before entering ERROR; 0 disables the timeout.
CW, 8, width of the wait counter; must satisfy TIMEOUT < 2^CW.

Ports:
clk  in  1  single clock; all state updates on rising edge.
rst  in  1  asynchronous, active-high reset.
imem_rdata  in  32  fetched instruction; valid when imem_ack=1.
imem_ack  in  1  instruction memory completion.
imem_req  out  1  instruction fetch request.
dmem_ack  in  1  data memory completion.
dmem_req  out  1  data access request.
alu_zero  in  1  ALU zero flag from the datapath (CBZ test).
ir_write  out  1  datapath IR load enable.
pc_write  out  1  PC update enable, one-cycle pulse.
pc_src  out  1  0 = PC+4, 1 = branch target.
reg2loc, alu_src, mem2reg, reg_write, mem_read, mem_write, branch, uncond_branch  out  1 each  datapath controls.
alu_op  out  2  00 add, 01 pass B, 10 funct-decoded.
state_o  out  3  current FSM state, for debug.
illegal  out  1  sticky; unknown opcode decoded.
timeout  out  1  sticky; memory ack not received within TIMEOUT.

Behaviour:
- One clock; reset is asynchronous and active-high. While rst=1 and in the cycle after release: state=FETCH, internal IR=0, wait counter=0, illegal=timeout=0. All outputs are Moore decodes of state plus latched IR, so imem_req=1 in the first post-reset cycle and every other output is 0.
- Decode of latched IR, first match wins:
  - IR[31:24]=8'd180: CBZ.
  - IR[31:26]=6'd5: B.
  - IR[31:21] in {10001011000, 11001011000, 10001010000, 10101010000}: R-type.
  - IR[31:21]=11'd1986: LDUR.
  - IR[31:21]=11'd1984: STUR.
  - Otherwise: illegal.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, ERROR=7.
- FETCH: imem_req=1. On imem_ack: internal IR<=imem_rdata, ir_write=1 in the same cycle, go to DECODE.
- DECODE: one cycle; drives reg2loc=1 for CBZ/STUR so operand reads settle.
  - Illegal opcode: go to ERROR and set illegal.
  - Otherwise go to EXEC.
- EXEC: alu_op and alu_src per class (R 10/0, LDUR/STUR 00/1, CBZ 01/0, B 00/0); reg2loc held.
  - CBZ: branch=1, pc_write=1, pc_src=alu_zero, go to FETCH.
  - B: uncond_branch=1, pc_write=1, pc_src=1, go to FETCH.
  - R-type: go to WB.
  - LDUR/STUR: go to MEM.
- MEM: dmem_req=1; mem_read=1 (LDUR) or mem_write=1 (STUR); alu_src=1 held.
  - On dmem_ack, LDUR: go to WB.
  - On dmem_ack, STUR: pc_write=1, pc_src=0, go to FETCH.
- WB: reg_write=1; mem2reg=1 for LDUR, else 0; pc_write=1, pc_src=0; go to FETCH.
- ERROR: all request, write and enable outputs held 0; remains in ERROR until rst.
- Latency with zero-wait memory (acks high on the first cycle):
  - R-type: 4 cycles.
  - LDUR: 5 cycles.
  - STUR: 4 cycles.
  - CBZ and B: 3 cycles.
- Wait counter:
  - Clears on entry to FETCH or MEM.
  - Increments each cycle that the req is high and the ack is low.
  - If TIMEOUT≠0 and the count reaches TIMEOUT with the ack still low: go to ERROR and set timeout.
  - An ack arriving in the same cycle as the limit wins; no timeout is raised.
- Acks received outside the matching state are ignored. imem_rdata is sampled only in FETCH with ack.
- Asynchronous reset mid-transaction aborts immediately: req drops and no pc_write or reg_write pulse is issued.
- pc_write, reg_write and ir_write never assert in the same cycle as each other, except that pc_write and reg_write share WB.

Decomposition:
- legv8_pkg holds:
  - opcode constants (OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_LDUR=1986, OP_STUR=1984, OP_CBZ=180, OP_B=5);
  - ALU_OP encodings;
  - the state enum (3 bits);
  - the instruction-class enum {CLS_R, CLS_LD, CLS_ST, CLS_CBZ, CLS_B, CLS_ILL}.
- One sub-module, legv8_instr_classify: combinational IR to class. The FSM, outputs and counter stay in the top module.

Test Plan:
- ADD 0x8B020020, acks immediate: exactly 4 cycles FETCH→DECODE→EXEC→WB; alu_op=10 in EXEC; reg_write=1 and pc_write=1 (pc_src=0) only in WB.
- LDUR (IR[31:21]=1986), dmem_ack delayed 3 cycles: MEM lasts 4 cycles with dmem_req=mem_read=1; WB has mem2reg=1, reg_write=1; total 8 cycles.
- CBZ (IR[31:24]=180): with alu_zero=1, EXEC shows pc_write=1, pc_src=1, branch=1; repeated with alu_zero=0, pc_src=0; no reg_write either time.
- B (IR[31:26]=5): EXEC shows uncond_branch=1, pc_src=1; 3 cycles total; STUR shows mem_write=1, reg2loc=1, pc_write on the ack cycle.
- IR=0xFFFFFFFF: DECODE→ERROR, illegal=1 and sticky, imem_req=0 thereafter; rst restores FETCH with illegal=0.
- TIMEOUT=4, imem_ack held low: ERROR after 4 request cycles with timeout=1; repeat with ack on the 4th cycle → no timeout. Assert rst mid-MEM → dmem_req drops asynchronously, no write pulse.
